// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   state_t      : sequencer states (IDLE / BUSY / ACK)
//   PORT0/PORT1  : port identifiers used for grant and last_grant
//   wdog_width() : watchdog counter width for a given TIMEOUT
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // A TIMEOUT of 0 disables the watchdog; keep a 1-bit counter so no
  // zero-width vector is ever declared.
  function automatic int wdog_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-requester grant selection (purely combinational).
//   i_req0/i_req1  : port requests
//   i_last_grant   : port that completed the previous transfer
//   o_grant        : winning port id (valid only when o_valid)
//   o_valid        : at least one request present
module rr_arbiter2
  import sram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = PORT0;
    if (i_req0 && i_req1) begin
      // Contention: fixed priority favours port 0, otherwise alternate.
      o_grant = (FIXED_PRIO != 0) ? PORT0 : ~i_last_grant;
    end else if (i_req1) begin
      o_grant = PORT1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter/sequencer in front of the single external-SRAM controller.
// Grants one whole transfer at a time to port 0 (CPU) or port 1 (DMA),
// drives the controller strobes until mem_ready, returns read data and
// pulses ack (plus err when the watchdog aborts a hung transfer).
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_req*/i_we*/i_addr*/i_wdata* : port requests, held until ack
//   o_rdata*                : read data, valid in ack cycle, held until next ack
//   o_ack*/o_err*           : one-cycle completion / timeout pulses
//   o_mem_addr/o_mem_wdata/o_mem_rd/o_mem_wr : to SRAM controller
//   i_mem_rdata/i_mem_ready : from SRAM controller
// All outputs are registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic [DW-1:0] o_rdata0,
  output logic [DW-1:0] o_rdata1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_err0,
  output logic          o_err1,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ready
);

  localparam int             WDW     = wdog_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t          r_state, w_next;
  logic            r_last, r_win;
  logic [WDW-1:0]  r_wdog;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata, r_rdata0, r_rdata1;
  logic            r_mem_rd, r_mem_wr, r_ack0, r_ack1, r_err0, r_err1;
  logic            w_grant, w_valid, w_we, w_timeout;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .i_req0       (i_req0),
    .i_req1       (i_req1),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  assign w_we      = w_grant ? i_we1 : i_we0;
  assign w_timeout = (TIMEOUT != 0) && (r_wdog == WD_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_next = ST_BUSY;
      ST_BUSY: if (i_mem_ready || w_timeout) w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;  // requests deliberately not sampled here
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last      <= PORT1;  // so port 0 wins the first contention
      r_win       <= PORT0;
      r_wdog      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_valid) begin
          r_win       <= w_grant;
          r_mem_addr  <= w_grant ? i_addr1  : i_addr0;
          r_mem_wdata <= w_grant ? i_wdata1 : i_wdata0;
          r_mem_rd    <= ~w_we;
          r_mem_wr    <= w_we;
          r_wdog      <= '0;
        end
        ST_BUSY: begin
          if (i_mem_ready) begin
            // Completion takes precedence over a same-cycle timeout.
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_mem_rd) begin
              if (r_win) r_rdata1 <= i_mem_rdata;
              else       r_rdata0 <= i_mem_rdata;
            end
            r_ack0 <= ~r_win;
            r_ack1 <= r_win;
          end else begin
            if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
            if (w_timeout) begin
              r_mem_rd <= 1'b0;
              r_mem_wr <= 1'b0;
              r_ack0   <= ~r_win;
              r_ack1   <= r_win;
              r_err0   <= ~r_win;
              r_err1   <= r_win;
            end
          end
        end
        ST_ACK:  r_last <= r_win;
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_err0      = r_err0;
  assign o_err1      = r_err1;

endmodule
